wb_stage: RTL and testbench

Final (writeback) pipeline stage of the 5-stage MIPS core. It consumes the memory-stage result bus and commits register writes, with byte enables to support LWL/LWR merging. It also hosts the CP0 register file: Count, Compare, Status, Cause, EPC and BadVAddr. It commits exceptions, ERET and interrupts, drives the pipeline-wide flush with a redirect PC, and emits the debug trace.

---
 rtl/wb_stage.sv | 211 +++++++++++++++++++++
 tb/tb_wb_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage of the 5-stage MIPS core: commits register writes, hosts the
// CP0 registers (Count/Compare/Status/Cause/EPC/BadVAddr) and raises flushes.
module wb_stage #(
  parameter int          MS_TO_WS_BUS_WD = 123,
  parameter logic [31:0] EX_ENTRY        = 32'hBFC0_0380
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_to_ws_valid,
  input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic                       ws_allowin,
  input  logic [5:0]                 ext_int_in,
  output logic [3:0]                 rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [31:0]                rf_wdata,
  output logic [41:0]                ws_fwd_bus,
  output logic                       flush,
  output logic [31:0]                flush_pc,
  output logic [31:0]                debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_wen,
  output logic [4:0]                 debug_wb_rf_wnum,
  output logic [31:0]                debug_wb_rf_wdata
);

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  logic                       ws_valid_reg;
  logic [MS_TO_WS_BUS_WD-1:0] bus_reg;
  logic                       ws_ready_go;

  // Latched bus fields
  logic [31:0] bus_badvaddr;
  logic        c0_eret;
  logic        c0_mtc0;
  logic        c0_mfc0;
  logic [4:0]  c0_rd;
  logic [2:0]  c0_sel;
  logic        bus_bd;
  logic        bus_ex;
  logic [4:0]  bus_excode;
  logic [3:0]  bus_rf_we;
  logic [4:0]  bus_dest;
  logic [31:0] bus_result;
  logic [31:0] bus_pc;

  // CP0 state
  logic [7:0]  status_im_reg;
  logic        status_exl_reg;
  logic        status_ie_reg;
  logic        cause_bd_reg;
  logic        cause_ti_reg;
  logic [5:0]  cause_ip_hw_reg;
  logic [1:0]  cause_ip_sw_reg;
  logic [4:0]  cause_exc_reg;
  logic [31:0] epc_reg;
  logic [31:0] badvaddr_reg;
  logic [31:0] count_reg;
  logic [31:0] compare_reg;
  logic        tick_reg;

  logic [31:0] status_val;
  logic [31:0] cause_val;
  logic [31:0] cp0_rdata;
  logic        int_pend;
  logic        ws_ex;
  logic [4:0]  ex_code;
  logic        eret_commit;
  logic        mtc0_commit;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic        wr_count;
  logic        wr_compare;
  logic        block_valid;

  assign ws_ready_go = 1'b1;
  assign ws_allowin  = !ws_valid_reg || ws_ready_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid_reg <= 1'b0;
      bus_reg      <= '0;
    end else begin
      if (ws_allowin) ws_valid_reg <= ms_to_ws_valid;
      if (ms_to_ws_valid && ws_allowin) bus_reg <= ms_to_ws_bus;
    end
  end

  assign bus_badvaddr = bus_reg[122:91];
  assign c0_eret      = bus_reg[90];
  assign c0_mtc0      = bus_reg[89];
  assign c0_mfc0      = bus_reg[88];
  assign c0_rd        = bus_reg[87:83];
  assign c0_sel       = bus_reg[82:80];
  assign bus_bd       = bus_reg[79];
  assign bus_ex       = bus_reg[78];
  assign bus_excode   = bus_reg[77:73];
  assign bus_rf_we    = bus_reg[72:69];
  assign bus_dest     = bus_reg[68:64];
  assign bus_result   = bus_reg[63:32];
  assign bus_pc       = bus_reg[31:0];

  // BEV (bit 22) is hardwired to 1
  assign status_val = {9'd0, 1'b1, 6'd0, status_im_reg, 6'd0, status_exl_reg, status_ie_reg};
  assign cause_val  = {cause_bd_reg, cause_ti_reg, 14'd0, cause_ip_hw_reg, cause_ip_sw_reg,
                       1'b0, cause_exc_reg, 2'b00};

  assign int_pend = status_ie_reg && !status_exl_reg &&
                    (|({cause_ip_hw_reg, cause_ip_sw_reg} & status_im_reg));
  assign ws_ex    = ws_valid_reg && (bus_ex || int_pend);
  assign ex_code  = bus_ex ? bus_excode : 5'h00;

  assign eret_commit = ws_valid_reg && c0_eret && !ws_ex;
  assign mtc0_commit = ws_valid_reg && c0_mtc0 && !ws_ex && (c0_sel == 3'd0);
  assign wr_status   = mtc0_commit && (c0_rd == CP0_STATUS);
  assign wr_cause    = mtc0_commit && (c0_rd == CP0_CAUSE);
  assign wr_epc      = mtc0_commit && (c0_rd == CP0_EPC);
  assign wr_count    = mtc0_commit && (c0_rd == CP0_COUNT);
  assign wr_compare  = mtc0_commit && (c0_rd == CP0_COMPARE);

  always_comb begin
    cp0_rdata = 32'd0;
    if (c0_sel == 3'd0) begin
      case (c0_rd)
        CP0_BADVADDR: cp0_rdata = badvaddr_reg;
        CP0_COUNT:    cp0_rdata = count_reg;
        CP0_COMPARE:  cp0_rdata = compare_reg;
        CP0_STATUS:   cp0_rdata = status_val;
        CP0_CAUSE:    cp0_rdata = cause_val;
        CP0_EPC:      cp0_rdata = epc_reg;
        default:      cp0_rdata = 32'd0;
      endcase
    end
  end

  // Exception, ERET and MTC0 commit; an exception suppresses the MTC0
  always_ff @(posedge clk) begin
    if (reset) begin
      status_im_reg   <= 8'd0;
      status_exl_reg  <= 1'b0;
      status_ie_reg   <= 1'b0;
      cause_bd_reg    <= 1'b0;
      cause_ip_sw_reg <= 2'd0;
      cause_exc_reg   <= 5'd0;
      epc_reg         <= 32'd0;
      badvaddr_reg    <= 32'd0;
      compare_reg     <= 32'd0;
    end else if (ws_ex) begin
      if (!status_exl_reg) begin
        epc_reg      <= bus_bd ? bus_pc - 32'd4 : bus_pc;
        cause_bd_reg <= bus_bd;
      end
      status_exl_reg <= 1'b1;
      cause_exc_reg  <= ex_code;
      if (ex_code == 5'h04 || ex_code == 5'h05) badvaddr_reg <= bus_badvaddr;
    end else begin
      if (eret_commit) status_exl_reg <= 1'b0;
      if (wr_status) begin
        status_im_reg  <= bus_result[15:8];
        status_exl_reg <= bus_result[1];
        status_ie_reg  <= bus_result[0];
      end
      if (wr_cause)   cause_ip_sw_reg <= bus_result[9:8];
      if (wr_epc)     epc_reg         <= bus_result;
      if (wr_compare) compare_reg     <= bus_result;
    end
  end

  // Count advances every other cycle; a software write takes precedence
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_reg  <= 1'b0;
      count_reg <= 32'd0;
    end else begin
      tick_reg <= ~tick_reg;
      if (wr_count)      count_reg <= bus_result;
      else if (tick_reg) count_reg <= count_reg + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cause_ti_reg    <= 1'b0;
      cause_ip_hw_reg <= 6'd0;
    end else begin
      if (wr_compare)                     cause_ti_reg <= 1'b0;
      else if (count_reg == compare_reg)  cause_ti_reg <= 1'b1;
      cause_ip_hw_reg <= {cause_ti_reg | ext_int_in[5], ext_int_in[4:0]};
    end
  end

  assign flush    = !reset && ws_valid_reg && (ws_ex || c0_eret);
  assign flush_pc = !flush ? 32'd0 : (ws_ex ? EX_ENTRY : epc_reg);

  assign rf_we       = {4{ws_valid_reg && !ws_ex}} & bus_rf_we;
  assign rf_waddr    = ws_valid_reg ? bus_dest : 5'd0;
  assign rf_wdata    = !ws_valid_reg ? 32'd0 : (c0_mfc0 ? cp0_rdata : bus_result);
  assign block_valid = ws_valid_reg && (|bus_rf_we) && !ws_ex;
  assign ws_fwd_bus  = {rf_we, block_valid, rf_waddr, rf_wdata};

  assign debug_wb_pc       = ws_valid_reg ? bus_pc : 32'd0;
  assign debug_wb_rf_wen   = rf_we;
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: a table of instructions with expected commit results,
// scored through a queue, plus a hand-written mid-operation reset sequence.
module tb_wb_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         ms_to_ws_valid;
  logic [122:0] ms_to_ws_bus;
  logic         ws_allowin;
  logic [5:0]   ext_int_in;
  logic [3:0]   rf_we;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata;
  logic [41:0]  ws_fwd_bus;
  logic         flush;
  logic [31:0]  flush_pc;
  logic [31:0]  debug_wb_pc;
  logic [3:0]   debug_wb_rf_wen;
  logic [4:0]   debug_wb_rf_wnum;
  logic [31:0]  debug_wb_rf_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .ws_allowin(ws_allowin), .ext_int_in(ext_int_in), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .ws_fwd_bus(ws_fwd_bus), .flush(flush), .flush_pc(flush_pc),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  typedef struct {
    string        name;
    int           idle;
    logic [122:0] bus;
    logic [3:0]   we;
    logic [4:0]   waddr;
    logic [31:0]  wdata;
    logic         fl;
    logic [31:0]  fpc;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic logic [10:0] mtc0(input logic [4:0] rd);
    return {3'b010, rd, 3'd0};
  endfunction

  function automatic logic [10:0] mfc0(input logic [4:0] rd, input logic [2:0] sel);
    return {3'b001, rd, sel};
  endfunction

  function automatic logic [122:0] mk(input logic [31:0] bv, input logic [10:0] c0,
                                      input logic bd, input logic ex, input logic [4:0] code,
                                      input logic [3:0] we, input logic [4:0] dest,
                                      input logic [31:0] res, input logic [31:0] pc);
    return {bv, c0, bd, ex, code, we, dest, res, pc};
  endfunction

  task automatic add(input string n, input int idle, input logic [122:0] b, input logic [3:0] we,
                     input logic [4:0] wa, input logic [31:0] wd, input logic fl,
                     input logic [31:0] fpc);
    vec_t v;
    v.name = n; v.idle = idle; v.bus = b; v.we = we; v.waddr = wa; v.wdata = wd;
    v.fl = fl; v.fpc = fpc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one instruction, score it one cycle later
  task automatic run(input vec_t x);
    vec_t e;
    logic [41:0] fwd_exp;
    repeat (x.idle) @(negedge clk);
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus   = x.bus;
    sb.push_back(x);
    @(negedge clk);
    ms_to_ws_valid = 1'b0;
    ms_to_ws_bus   = '0;
    e = sb.pop_front();
    fwd_exp = {e.we, |e.we, e.waddr, e.wdata};
    chk({e.name, ".rf_we"}, 64'(rf_we), 64'(e.we));
    chk({e.name, ".rf_waddr"}, 64'(rf_waddr), 64'(e.waddr));
    chk({e.name, ".rf_wdata"}, 64'(rf_wdata), 64'(e.wdata));
    chk({e.name, ".flush"}, 64'(flush), 64'(e.fl));
    if (e.fl) chk({e.name, ".flush_pc"}, 64'(flush_pc), 64'(e.fpc));
    chk({e.name, ".debug"}, {debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum},
        64'({e.bus[31:0], e.we, e.waddr}));
    chk({e.name, ".debug_wdata"}, 64'(debug_wb_rf_wdata), 64'(e.wdata));
    chk({e.name, ".fwd"}, 64'(ws_fwd_bus), 64'(fwd_exp));
    $display("txn %-16s pc=%h we=%h waddr=%0d wdata=%h flush=%b flush_pc=%h",
             e.name, debug_wb_pc, rf_we, rf_waddr, rf_wdata, flush, flush_pc);
  endtask

  localparam logic [4:0] R_BADV = 5'd8, R_COUNT = 5'd9, R_CMP = 5'd11;
  localparam logic [4:0] R_STATUS = 5'd12, R_CAUSE = 5'd13, R_EPC = 5'd14;
  localparam logic [10:0] ERET = 11'b100_00000_000;
  localparam logic [31:0] EXV = 32'hBFC0_0380;

  initial begin
    // Initial Compare==Count==0 sets TI; the first write moves Compare out of reach
    add("mtc0_compare", 0, mk(0, mtc0(R_CMP), 0, 0, 0, 4'h0, 0, 32'hFFFF_0000, 32'hBFC0_0000), 4'h0, 0, 32'hFFFF_0000, 0, 0);
    add("alu",          0, mk(0, 0, 0, 0, 0, 4'hF, 5, 32'h1234, 32'hBFC0_0010), 4'hF, 5, 32'h1234, 0, 0);
    add("lwl",          0, mk(0, 0, 0, 0, 0, 4'hC, 7, 32'hAABB_CCDD, 32'hBFC0_0014), 4'hC, 7, 32'hAABB_CCDD, 0, 0);
    add("rd_status",    0, mk(0, mfc0(R_STATUS, 0), 0, 0, 0, 4'hF, 3, 0, 32'hBFC0_0018), 4'hF, 3, 32'h0040_0000, 0, 0);
    add("rd_cause",     0, mk(0, mfc0(R_CAUSE, 0), 0, 0, 0, 4'hF, 3, 0, 32'hBFC0_001C), 4'hF, 3, 32'h0, 0, 0);
    add("adel_bd",      0, mk(32'h1001, 0, 1, 1, 5'h04, 4'hF, 2, 32'hDEAD, 32'hBFC0_0104), 4'h0, 2, 32'hDEAD, 1, EXV);
    add("rd_epc",       0, mk(0, mfc0(R_EPC, 0), 0, 0, 0, 4'hF, 3, 0, 32'hBFC0_0380), 4'hF, 3, 32'hBFC0_0100, 0, 0);
    add("rd_cause_ex",  0, mk(0, mfc0(R_CAUSE, 0), 0, 0, 0, 4'hF, 3, 0, 32'hBFC0_0384), 4'hF, 3, 32'h8000_0010, 0, 0);
    add("rd_badv",      0, mk(0, mfc0(R_BADV, 0), 0, 0, 0, 4'hF, 3, 0, 32'hBFC0_0388), 4'hF, 3, 32'h1001, 0, 0);
    add("rd_status_exl",0, mk(0, mfc0(R_STATUS, 0), 0, 0, 0, 4'hF, 3, 0, 32'hBFC0_038C), 4'hF, 3, 32'h0040_0002, 0, 0);
    add("ov_nested",    0, mk(32'h2222, 0, 0, 1, 5'h0C, 4'hF, 4, 32'h55, 32'hBFC0_0500), 4'h0, 4, 32'h55, 1, EXV);
    add("rd_epc2",      0, mk(0, mfc0(R_EPC, 0), 0, 0, 0, 4'hF, 3, 0, 32'hBFC0_0390), 4'hF, 3, 32'hBFC0_0100, 0, 0);
    add("rd_cause2",    0, mk(0, mfc0(R_CAUSE, 0), 0, 0, 0, 4'hF, 3, 0, 32'hBFC0_0394), 4'hF, 3, 32'h8000_0030, 0, 0);
    add("rd_badv2",     0, mk(0, mfc0(R_BADV, 0), 0, 0, 0, 4'hF, 3, 0, 32'hBFC0_0398), 4'hF, 3, 32'h1001, 0, 0);
    add("mtc0_epc",     0, mk(0, mtc0(R_EPC), 0, 0, 0, 4'h0, 0, 32'hBFC0_0200, 32'hBFC0_039C), 4'h0, 0, 32'hBFC0_0200, 0, 0);
    add("eret",         0, mk(0, ERET, 0, 0, 0, 4'h0, 0, 0, 32'hBFC0_03A0), 4'h0, 0, 32'h0, 1, 32'hBFC0_0200);
    add("rd_status_er", 0, mk(0, mfc0(R_STATUS, 0), 0, 0, 0, 4'hF, 3, 0, 32'hBFC0_0200), 4'hF, 3, 32'h0040_0000, 0, 0);
    add("mtc0_badv_ro", 0, mk(0, mtc0(R_BADV), 0, 0, 0, 4'h0, 0, 32'h0, 32'hBFC0_0204), 4'h0, 0, 32'h0, 0, 0);
    add("rd_badv3",     0, mk(0, mfc0(R_BADV, 0), 0, 0, 0, 4'hF, 3, 0, 32'hBFC0_0208), 4'hF, 3, 32'h1001, 0, 0);
    add("rd_sel1",      0, mk(0, mfc0(R_STATUS, 3'd1), 0, 0, 0, 4'hF, 3, 0, 32'hBFC0_020C), 4'hF, 3, 32'h0, 0, 0);
    add("mtc0_cmp_ex",  0, mk(0, mtc0(R_CMP), 0, 1, 5'h0A, 4'h0, 0, 32'h7, 32'hBFC0_0600), 4'h0, 0, 32'h7, 1, EXV);
    add("rd_compare",   0, mk(0, mfc0(R_CMP, 0), 0, 0, 0, 4'hF, 3, 0, 32'hBFC0_0380), 4'hF, 3, 32'hFFFF_0000, 0, 0);
    add("rd_epc3",      0, mk(0, mfc0(R_EPC, 0), 0, 0, 0, 4'hF, 3, 0, 32'hBFC0_0384), 4'hF, 3, 32'hBFC0_0600, 0, 0);
    add("eret2",        0, mk(0, ERET, 0, 0, 0, 4'h0, 0, 0, 32'hBFC0_0388), 4'h0, 0, 32'h0, 1, 32'hBFC0_0600);
    add("mtc0_status",  0, mk(0, mtc0(R_STATUS), 0, 0, 0, 4'h0, 0, 32'hFFBF_8001, 32'hBFC0_0600), 4'h0, 0, 32'hFFBF_8001, 0, 0);
    add("rd_status3",   0, mk(0, mfc0(R_STATUS, 0), 0, 0, 0, 4'hF, 3, 0, 32'hBFC0_0604), 4'hF, 3, 32'h0040_8001, 0, 0);
    add("mtc0_cmp6",    0, mk(0, mtc0(R_CMP), 0, 0, 0, 4'h0, 0, 32'd6, 32'hBFC0_0608), 4'h0, 0, 32'd6, 0, 0);
    add("mtc0_count0",  0, mk(0, mtc0(R_COUNT), 0, 0, 0, 4'h0, 0, 32'd0, 32'hBFC0_060C), 4'h0, 0, 32'd0, 0, 0);
    add("timer_int",   20, mk(0, 0, 0, 0, 0, 4'hF, 9, 32'h77, 32'hBFC0_0700), 4'h0, 9, 32'h77, 1, EXV);
    add("rd_cause_ti",  0, mk(0, mfc0(R_CAUSE, 0), 0, 0, 0, 4'hF, 3, 0, 32'hBFC0_0380), 4'hF, 3, 32'h4000_8000, 0, 0);
    add("rd_epc4",      0, mk(0, mfc0(R_EPC, 0), 0, 0, 0, 4'hF, 3, 0, 32'hBFC0_0384), 4'hF, 3, 32'hBFC0_0700, 0, 0);
    add("mtc0_cmp_clr", 0, mk(0, mtc0(R_CMP), 0, 0, 0, 4'h0, 0, 32'hFFFF_0000, 32'hBFC0_0388), 4'h0, 0, 32'hFFFF_0000, 0, 0);
    add("rd_cause_clr", 2, mk(0, mfc0(R_CAUSE, 0), 0, 0, 0, 4'hF, 3, 0, 32'hBFC0_038C), 4'hF, 3, 32'h0, 0, 0);
    add("mtc0_cause",   0, mk(0, mtc0(R_CAUSE), 0, 0, 0, 4'h0, 0, 32'hFFFF_FFFF, 32'hBFC0_0390), 4'h0, 0, 32'hFFFF_FFFF, 0, 0);
    add("rd_cause_sw",  0, mk(0, mfc0(R_CAUSE, 0), 0, 0, 0, 4'hF, 3, 0, 32'hBFC0_0394), 4'hF, 3, 32'h0000_0300, 0, 0);

    reset = 1'b1;
    ms_to_ws_valid = 1'b0;
    ms_to_ws_bus = '0;
    ext_int_in = 6'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset.rf_we", 64'(rf_we), 64'h0);
    chk("reset.flush", 64'(flush), 64'h0);
    chk("reset.debug_pc", 64'(debug_wb_pc), 64'h0);
    chk("reset.fwd", 64'(ws_fwd_bus), 64'h0);
    chk("reset.allowin", 64'(ws_allowin), 64'h1);
    $display("txn %-16s we=%h flush=%b pc=%h", "reset", rf_we, flush, debug_wb_pc);

    foreach (vecs[i]) run(vecs[i]);

    // Reset arriving while an exception sits in the stage drops its flush
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus = mk(32'h3003, 0, 0, 1, 5'h05, 4'hF, 6, 32'h1, 32'hBFC0_0800);
    @(negedge clk);
    ms_to_ws_valid = 1'b0;
    ms_to_ws_bus = '0;
    chk("pre_reset.flush", 64'(flush), 64'h1);
    reset = 1'b1;
    #1;
    chk("in_reset.flush", 64'(flush), 64'h0);
    $display("txn %-16s flush=%b", "mid_reset", flush);
    @(negedge clk);
    reset = 1'b0;
    chk("post_reset.rf_we", 64'(rf_we), 64'h0);
    chk("post_reset.pc", 64'(debug_wb_pc), 64'h0);
    vecs.delete();
    add("rst_status", 0, mk(0, mfc0(R_STATUS, 0), 0, 0, 0, 4'hF, 3, 0, 32'hBFC0_0000), 4'hF, 3, 32'h0040_0000, 0, 0);
    add("rst_epc",    0, mk(0, mfc0(R_EPC, 0), 0, 0, 0, 4'hF, 3, 0, 32'hBFC0_0004), 4'hF, 3, 32'h0, 0, 0);
    add("rst_badv",   0, mk(0, mfc0(R_BADV, 0), 0, 0, 0, 4'hF, 3, 0, 32'hBFC0_0008), 4'hF, 3, 32'h0, 0, 0);
    add("rst_compare",0, mk(0, mfc0(R_CMP, 0), 0, 0, 0, 4'hF, 3, 0, 32'hBFC0_000C), 4'hF, 3, 32'h0, 0, 0);
    foreach (vecs[i]) run(vecs[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
